// File: rtl/tty_tx_if.sv
// tty_tx_if: handshake between the CPU IOT decoder and the teleprinter output device
interface tty_tx_if;
   logic       load;
   logic [7:0] dataout;
   logic       clear;
   logic       ready;
   logic       busy;
   logic       overrun;
   modport master (output load, dataout, clear, input ready, busy, overrun);
   modport slave  (input load, dataout, clear, output ready, busy, overrun);
endinterface

// File: rtl/tty_tx_device.sv
// tty_tx_device: IOT teleprinter output, LSB-first async serial with a one-entry holding register; define TTY_TX_PARITY_EN for an even-parity bit
module tty_tx_device #(
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1
) (
   input  logic    clk,
   input  logic    rst,
   tty_tx_if.slave bus,
   output logic    tx
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CLAST = CW'(CLKS_PER_BIT - 1);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`ifdef TTY_TX_PARITY_EN
   localparam state_t AFTER_DATA = PARITY;
`else
   localparam state_t AFTER_DATA = STOP;
`endif
   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    bit_idx, bit_idx_n;
   logic          stop_idx, stop_idx_n;
   logic [7:0]    shift, shift_n, hold, hold_n;
   logic          hold_full, hold_full_n;
   logic          start_new, accept_hold;
   logic          tx_n, rdy, rdy_n, bsy, bsy_n, ovr, ovr_n;
   logic          bit_end, frame_end;
   assign bit_end     = cnt == CLAST;
   assign frame_end   = state == STOP && bit_end && stop_idx == 1'(STOP_BITS - 1);
   assign bus.ready   = rdy;
   assign bus.busy    = bsy;
   assign bus.overrun = ovr;
   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end
   // next state: a new frame starts straight from the last stop cycle when a character is waiting
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = bus.load ? START : IDLE;
         START:   state_n = bit_end ? DATA : START;
         DATA:    state_n = (bit_end && bit_idx == 3'd7) ? AFTER_DATA : DATA;
         PARITY:  state_n = bit_end ? STOP : PARITY;
         STOP:    state_n = frame_end ? ((hold_full || bus.load) ? START : IDLE) : STOP;
         default: state_n = IDLE;
      endcase
   end
   // datapath and output next values; the holding char always leaves before a new one lands
   always_comb begin
      start_new   = (state == IDLE && bus.load) || (frame_end && (hold_full || bus.load));
      accept_hold = bus.load && state != IDLE && !(frame_end && !hold_full);
      cnt_n       = (state == IDLE || bit_end) ? '0 : cnt + CW'(1);
      bit_idx_n   = state != DATA ? 3'd0 : bit_idx + 3'(bit_end);
      stop_idx_n  = (state != STOP || frame_end) ? 1'b0 : stop_idx ^ bit_end;
      shift_n     = start_new ? (hold_full ? hold : bus.dataout) : shift;
      hold_n      = accept_hold ? bus.dataout : hold;
      hold_full_n = accept_hold || (hold_full && !frame_end);
      tx_n        = state_n == START ? 1'b0 : state_n == DATA ? shift_n[bit_idx_n] : state_n == PARITY ? ^shift_n : 1'b1;
      rdy_n       = frame_end || (rdy && !(bus.load || bus.clear));
      bsy_n       = state_n != IDLE || hold_full_n;
      ovr_n       = bus.load && hold_full && !frame_end;
   end
   // datapath and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         bit_idx   <= '0;
         stop_idx  <= 1'b0;
         shift     <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
         tx        <= 1'b1;
         rdy       <= 1'b0;
         bsy       <= 1'b0;
         ovr       <= 1'b0;
      end else begin
         cnt       <= cnt_n;
         bit_idx   <= bit_idx_n;
         stop_idx  <= stop_idx_n;
         shift     <= shift_n;
         hold      <= hold_n;
         hold_full <= hold_full_n;
         tx        <= tx_n;
         rdy       <= rdy_n;
         bsy       <= bsy_n;
         ovr       <= ovr_n;
      end
   end
endmodule
